// File: rtl/aud_pkg.sv
// Shared constants and types for the I2S audio output path.
// Frame layout is {left, right}, each channel MSB first.
package aud_pkg;

  localparam int AUD_WIDTH      = 16;
  localparam int AUD_FRAME_BITS = 2 * AUD_WIDTH;
  localparam int LEFT_MSB       = AUD_FRAME_BITS - 1;
  localparam int RIGHT_MSB      = AUD_WIDTH - 1;

  // The bit clock divider counts in 8 bits, which covers DIV up to 255.
  localparam int DIV_CNT_W = 8;

  // What the serializer does with its shift register on a given clk edge.
  typedef enum logic [1:0] {
    EV_IDLE,
    EV_SHIFT,
    EV_LOAD,
    EV_UNDERRUN
  } slot_evt_e;

endpackage

// File: rtl/aud_out_i2s_tx_if.sv
// Ready-to-send / ready-to-receive sample handshake between the filter and the I2S serializer.
interface aud_out_i2s_tx_if #(
  parameter int WIDTH = aud_pkg::AUD_WIDTH
);

  logic [2*WIDTH-1:0] tx_aud_in;
  logic               tx_aud_in_rts;
  logic               tx_aud_in_rtr;

  modport master (
    output tx_aud_in,
    output tx_aud_in_rts,
    input  tx_aud_in_rtr
  );

  modport slave (
    input  tx_aud_in,
    input  tx_aud_in_rts,
    output tx_aud_in_rtr
  );

endinterface

// File: rtl/i2s_sck_gen.sv
// Bit clock generator: divides clk by 2*DIV and strobes fall_evt on the clk edge
// where i2s_sck goes from 1 to 0. Everything is held at zero while disabled.
module i2s_sck_gen
  import aud_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rstb,
  input  logic tx_enable,
  output logic i2s_sck,
  output logic fall_evt
);

  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(DIV - 1);

  logic [DIV_CNT_W-1:0] div_cnt;
  logic                 wrap;

  assign wrap     = tx_enable && (div_cnt == DIV_LAST);
  // Combinational so the serializer updates ws/sd on the very edge sck falls.
  assign fall_evt = wrap && i2s_sck;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      div_cnt <= '0;
      i2s_sck <= 1'b0;
    end else if (!tx_enable) begin
      div_cnt <= '0;
      i2s_sck <= 1'b0;
    end else if (wrap) begin
      div_cnt <= '0;
      i2s_sck <= ~i2s_sck;
    end else begin
      div_cnt <= div_cnt + DIV_CNT_W'(1);
    end
  end

endmodule

// File: rtl/aud_out_i2s_tx.sv
// I2S transmitter: holds one stereo word from the filter handshake and shifts it out
// as {left, right} MSB first, flagging underrun when a frame starts with no word held.
module aud_out_i2s_tx
  import aud_pkg::*;
#(
  parameter int DIV   = 4,
  parameter int WIDTH = AUD_WIDTH
) (
  input  logic                    clk,
  input  logic                    rstb,
  input  logic                    tx_enable,
  aud_out_i2s_tx_if.slave         aud,
  output logic                    i2s_sck,
  output logic                    i2s_ws,
  output logic                    i2s_sd,
  output logic                    tx_underrun
);

  localparam int FRAME  = 2 * WIDTH;
  localparam int SLOT_W = $clog2(FRAME);

  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(FRAME - 1);
  // ws leads each channel by one slot: high from the last left slot to the
  // second-to-last right slot.
  localparam logic [SLOT_W-1:0] WS_FIRST  = SLOT_W'(WIDTH - 1);
  localparam logic [SLOT_W-1:0] WS_LAST   = SLOT_W'(FRAME - 2);

  logic              fall_evt;
  logic              transfer;
  logic              frame_start;

  logic [FRAME-1:0]  hold_q;
  logic              hold_valid;
  logic              hold_valid_nxt;

  logic [FRAME-1:0]  shift_q;
  logic [FRAME-1:0]  shift_nxt;
  logic [SLOT_W-1:0] slot_cnt;
  logic [SLOT_W-1:0] slot_nxt;
  // Cleared while disabled so the first fall after enable is treated as slot 0.
  logic              primed;
  slot_evt_e         evt;

  i2s_sck_gen #(
    .DIV (DIV)
  ) u_sck_gen (
    .clk       (clk),
    .rstb      (rstb),
    .tx_enable (tx_enable),
    .i2s_sck   (i2s_sck),
    .fall_evt  (fall_evt)
  );

  assign transfer    = aud.tx_aud_in_rts && aud.tx_aud_in_rtr;
  assign frame_start = fall_evt && (!primed || (slot_cnt == SLOT_LAST));

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    evt            = EV_IDLE;
    slot_nxt       = slot_cnt;
    shift_nxt      = shift_q;
    hold_valid_nxt = hold_valid;

    if (fall_evt) begin
      if (frame_start) begin
        slot_nxt = '0;
        if (hold_valid) begin
          evt            = EV_LOAD;
          shift_nxt      = hold_q;
          hold_valid_nxt = 1'b0;
        end else begin
          evt       = EV_UNDERRUN;
          shift_nxt = '0;
        end
      end else begin
        evt       = EV_SHIFT;
        slot_nxt  = slot_cnt + SLOT_W'(1);
        shift_nxt = {shift_q[FRAME-2:0], 1'b0};
      end
    end

    // A capture on a frame-start edge wins: the old word has already been loaded.
    if (transfer) begin
      hold_valid_nxt = 1'b1;
    end
  end

  // Handshake side keeps running while the serial side is disabled.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      // NOTE: the data registers are reset along with their valid flags so a
      // reset mid-frame can never replay a stale word.
      hold_q            <= '0;
      hold_valid        <= 1'b0;
      aud.tx_aud_in_rtr <= 1'b0;
    end else begin
      hold_valid        <= hold_valid_nxt;
      aud.tx_aud_in_rtr <= !hold_valid_nxt;
      if (transfer) begin
        hold_q <= aud.tx_aud_in;
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      slot_cnt    <= '0;
      primed      <= 1'b0;
      shift_q     <= '0;
      i2s_ws      <= 1'b0;
      i2s_sd      <= 1'b0;
      tx_underrun <= 1'b0;
    end else if (!tx_enable) begin
      slot_cnt    <= '0;
      primed      <= 1'b0;
      shift_q     <= '0;
      i2s_ws      <= 1'b0;
      i2s_sd      <= 1'b0;
      tx_underrun <= 1'b0;
    end else begin
      tx_underrun <= (evt == EV_UNDERRUN);
      if (fall_evt) begin
        slot_cnt <= slot_nxt;
        primed   <= 1'b1;
        shift_q  <= shift_nxt;
        i2s_sd   <= shift_nxt[FRAME-1];
        i2s_ws   <= (slot_nxt >= WS_FIRST) && (slot_nxt <= WS_LAST);
      end
    end
  end

endmodule

// File: tb/tb_aud_out_i2s_tx.sv
// Self-checking bench for aud_out_i2s_tx: cycle model from edge arithmetic, a DAC-style
// deserializer, a table of stereo words, and hand sequences for disable/reset/underrun.
module tb_aud_out_i2s_tx;
  import aud_pkg::*;

  localparam int DIV = 2;
  localparam int NV  = 6;

  logic clk       = 1'b0;
  logic rstb      = 1'b0;
  logic tx_enable = 1'b0;
  logic i2s_sck, i2s_ws, i2s_sd, tx_underrun;

  aud_out_i2s_tx_if #(.WIDTH(AUD_WIDTH)) aud ();

  aud_out_i2s_tx #(
    .DIV   (DIV),
    .WIDTH (AUD_WIDTH)
  ) dut (
    .clk         (clk),
    .rstb        (rstb),
    .tx_enable   (tx_enable),
    .aud         (aud),
    .i2s_sck     (i2s_sck),
    .i2s_ws      (i2s_ws),
    .i2s_sd      (i2s_sd),
    .tx_underrun (tx_underrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: sck/ws/sd follow from the number of enabled clk edges since enable.
  int unsigned m_en_edges = 0;
  int unsigned m_falls    = 0;
  bit          m_held     = 1'b0;
  bit          m_rtr      = 1'b0;
  bit          m_underrun = 1'b0;
  bit          xfer       = 1'b0;
  logic [31:0] m_hold     = '0;
  logic [31:0] m_frame    = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rstb);
      if (!rstb) begin
        m_en_edges = 0;
        m_falls    = 0;
        m_held     = 1'b0;
        m_rtr      = 1'b0;
        m_underrun = 1'b0;
        m_hold     = '0;
        m_frame    = '0;
      end else begin
        xfer       = aud.tx_aud_in_rts && m_rtr;
        m_underrun = 1'b0;
        if (tx_enable) begin
          m_en_edges++;
          if (m_en_edges % (2 * DIV) == 0) begin
            m_falls = m_en_edges / (2 * DIV);
            if ((m_falls - 1) % AUD_FRAME_BITS == 0) begin
              if (m_held) begin
                m_frame = m_hold;
                m_held  = 1'b0;
              end else begin
                m_frame    = '0;
                m_underrun = 1'b1;
              end
            end
          end
        end else begin
          m_en_edges = 0;
          m_falls    = 0;
        end
        if (xfer) begin
          m_held = 1'b1;
          m_hold = aud.tx_aud_in;
        end
        m_rtr = !m_held;
      end
    end
  end

  // Per-cycle comparison against the model, on the inactive clock edge.
  int   ur_cnt = 0;
  int   ur_run = 0;
  int   ur_last_len = 0;
  int   slot_now;
  logic e_sck, e_ws, e_sd;

  initial begin
    forever begin
      @(negedge clk);
      slot_now = (m_falls > 0) ? int'((m_falls - 1) % AUD_FRAME_BITS) : 0;
      e_sck    = ((m_en_edges / DIV) % 2) == 1;
      e_ws     = (m_falls > 0) && (slot_now >= 15) && (slot_now <= 30);
      e_sd     = (m_falls > 0) ? m_frame[31 - slot_now] : 1'b0;
      check("rtr",      32'(aud.tx_aud_in_rtr), 32'(m_rtr));
      check("sck",      32'(i2s_sck),           32'(e_sck));
      check("ws",       32'(i2s_ws),            32'(e_ws));
      check("sd",       32'(i2s_sd),            32'(e_sd));
      check("underrun", 32'(tx_underrun),       32'(m_underrun));
      if (tx_underrun) begin
        ur_run++;
      end else if (ur_run > 0) begin
        ur_last_len = ur_run;
        ur_run      = 0;
        ur_cnt++;
      end
    end
  end

  // DAC-style receiver: samples on sck rise; a ws change marks the LSB of the ending channel.
  logic [15:0] rx_sh   = '0;
  logic [15:0] rx_left = '0;
  logic        rx_prev_ws = 1'b0;
  logic [31:0] rx_q[$];

  initial begin
    forever begin
      @(posedge i2s_sck or negedge rstb);
      if (!rstb) begin
        rx_sh      = '0;
        rx_prev_ws = 1'b0;
      end else begin
        rx_sh = {rx_sh[14:0], i2s_sd};
        if (i2s_ws != rx_prev_ws) begin
          if (i2s_ws) rx_left = rx_sh;
          else        rx_q.push_back({rx_left, rx_sh});
        end
        rx_prev_ws = i2s_ws;
      end
    end
  end

  task automatic send_word(input logic [31:0] w, input string name);
    bit ok = 1'b0;
    aud.tx_aud_in     = w;
    aud.tx_aud_in_rts = 1'b1;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (aud.tx_aud_in_rtr) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) @(negedge clk);
    aud.tx_aud_in_rts = 1'b0;
    check({name, "_accept"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_rx(input int n, input string name);
    for (int i = 0; i < 600 && rx_q.size() < n; i++) @(negedge clk);
    check(name, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_ur(input int n, input string name);
    for (int i = 0; i < 600 && ur_cnt < n; i++) @(negedge clk);
    check(name, 32'(ur_cnt >= n), 32'd1);
  endtask

  task automatic wait_slot(input int s, input string name);
    bit hit = 1'b0;
    for (int i = 0; i < 600 && !hit; i++) begin
      @(negedge clk);
      if (m_falls > 0 && int'((m_falls - 1) % AUD_FRAME_BITS) == s) hit = 1'b1;
    end
    check(name, 32'(hit), 32'd1);
  endtask

  typedef struct {
    logic [31:0] word;
    logic [15:0] exp_left;
    logic [15:0] exp_right;
  } vec_t;

  vec_t        vecs[NV];
  logic [31:0] w_rand, w1, w2, w3;
  int          rise_t[$];
  int          sck_hi, rx_base, ur_base;
  logic        prev_sck;

  initial begin
    vecs[0] = '{32'hA5A5_3C3C, 16'hA5A5, 16'h3C3C};
    vecs[1] = '{32'h8000_0001, 16'h8000, 16'h0001};
    vecs[2] = '{32'h7FFF_FFFF, 16'h7FFF, 16'hFFFF};
    for (int i = 3; i < NV; i++) begin
      w_rand  = $urandom;
      vecs[i] = '{w_rand, w_rand[LEFT_MSB -: 16], w_rand[RIGHT_MSB -: 16]};
    end
    aud.tx_aud_in     = '0;
    aud.tx_aud_in_rts = 1'b0;

    // Reset and preload with the serial side disabled.
    repeat (3) @(negedge clk);
    check("reset_rtr",      32'(aud.tx_aud_in_rtr), 32'd0);
    check("reset_sck",      32'(i2s_sck),           32'd0);
    check("reset_ws",       32'(i2s_ws),            32'd0);
    check("reset_sd",       32'(i2s_sd),            32'd0);
    check("reset_underrun", 32'(tx_underrun),       32'd0);
    rstb = 1'b1;
    @(negedge clk);
    check("rtr_first_edge", 32'(aud.tx_aud_in_rtr), 32'd1);
    send_word(vecs[0].word, "preload");
    check("rtr_after_preload", 32'(aud.tx_aud_in_rtr), 32'd0);
    sck_hi = 0;
    repeat (40) begin
      @(negedge clk);
      if (i2s_sck) sck_hi++;
    end
    check("no_sck_disabled", 32'(sck_hi), 32'd0);

    // Enable and measure the bit clock period.
    tx_enable = 1'b1;
    prev_sck  = i2s_sck;
    for (int i = 0; i < 40 && rise_t.size() < 2; i++) begin
      @(negedge clk);
      if (i2s_sck && !prev_sck) rise_t.push_back(i);
      prev_sck = i2s_sck;
    end
    check("sck_period", 32'((rise_t.size() >= 2) ? (rise_t[1] - rise_t[0]) : 0), 32'(2 * DIV));

    // Stream the rest of the table back to back and compare the deserialized frames.
    for (int i = 1; i < NV; i++) send_word(vecs[i].word, $sformatf("stream%0d", i));
    wait_rx(NV, "stream_frames");
    for (int i = 0; i < NV; i++) begin
      check($sformatf("frame%0d_left", i),  32'(rx_q[i][31:16]), 32'(vecs[i].exp_left));
      check($sformatf("frame%0d_right", i), 32'(rx_q[i][15:0]),  32'(vecs[i].exp_right));
    end
    check("no_underrun_stream", 32'(ur_cnt), 32'd0);

    // Underrun: nothing more is sent.
    wait_ur(1, "underrun_seen");
    check("underrun_width", 32'(ur_last_len), 32'd1);
    wait_rx(NV + 1, "underrun_frame");
    check("underrun_data", rx_q[NV], 32'd0);

    // Disable at slot 7 of w1's frame with w2 held; w2 must start cleanly on re-enable.
    w1 = $urandom;
    w2 = $urandom;
    send_word(w1, "w1");
    send_word(w2, "w2");
    wait_slot(7, "slot7");
    rx_base   = rx_q.size();
    tx_enable = 1'b0;
    repeat (10) @(negedge clk);
    check("dis_sck", 32'(i2s_sck), 32'd0);
    check("dis_ws",  32'(i2s_ws),  32'd0);
    check("dis_sd",  32'(i2s_sd),  32'd0);
    tx_enable = 1'b1;
    wait_rx(rx_base + 1, "reenable_frame");
    check("reenable_data", rx_q[rx_base], w2);

    // Reset during slot 20 of w2's replay... the frame after re-enable, with w3 held.
    w3 = $urandom;
    send_word(w3, "w3");
    wait_slot(20, "slot20");
    rx_base = rx_q.size();
    ur_base = ur_cnt;
    #2 rstb = 1'b0;
    #1;
    check("midrst_rtr",      32'(aud.tx_aud_in_rtr), 32'd0);
    check("midrst_sck",      32'(i2s_sck),           32'd0);
    check("midrst_ws",       32'(i2s_ws),            32'd0);
    check("midrst_sd",       32'(i2s_sd),            32'd0);
    check("midrst_underrun", 32'(tx_underrun),       32'd0);
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    @(negedge clk);
    check("midrst_rtr_back", 32'(aud.tx_aud_in_rtr), 32'd1);
    wait_ur(ur_base + 1, "midrst_underrun_seen");
    wait_rx(rx_base + 1, "midrst_frame");
    check("midrst_data", rx_q[rx_base], 32'd0);

    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
